// File: rtl/debounced_key_encoder.sv
// Keypad front end: two-flop synchroniser, press/release debounce and one-hot to
// binary key encoding with a single-cycle keystrobe and optional auto-repeat.
//
// state      | meaning
// S_IDLE     | no key down, waiting for any nonzero synchronised sample
// S_DEBOUNCE | candidate sample seen, counting consecutive identical cycles
// S_PRESSED  | key accepted and still held; auto-repeat timing runs here
// S_RELEASE  | key went to zero, counting stable-zero cycles before IDLE
module debounced_key_encoder #(
  parameter int NUM_KEYS      = 13,
  parameter int CODE_W        = 4,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NUM_KEYS-1:0] keypad,
  output logic [CODE_W-1:0]   keycode,
  output logic                keystrobe,
  output logic                keyheld
);

  localparam int DB_W    = $clog2(DEBOUNCE + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_LIM  = DB_W'(DEBOUNCE);
  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  state_t              state;
  logic [NUM_KEYS-1:0] sync_q;
  logic [NUM_KEYS-1:0] keypad_s;
  logic [NUM_KEYS-1:0] sample;
  logic [DB_W-1:0]     db_cnt;
  logic [RPT_W-1:0]    rpt_cnt;
  logic                rpt_again;

  logic                sample_multi;
  logic                sample_seen;
  logic [CODE_W-1:0]   sample_code;
  logic [RPT_W-1:0]    rpt_nxt;
  logic [RPT_W-1:0]    rpt_lim;
  logic                s_zero;
  logic                s_same;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q   <= '0;
      keypad_s <= '0;
    end else begin
      sync_q   <= keypad;
      keypad_s <= sync_q;
    end
  end

  // Two or more lines down encode to the reserved all-ones code.
  always_comb begin
    sample_multi = 1'b0;
    sample_seen  = 1'b0;
    sample_code  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sample[i]) begin
        if (sample_seen) sample_multi = 1'b1;
        sample_seen = 1'b1;
        sample_code = CODE_W'(i);
      end
    end
    if (sample_multi) sample_code = '1;
  end

  assign rpt_nxt = rpt_cnt + RPT_ONE;
  assign rpt_lim = rpt_again ? RPT_PER : RPT_DLY;
  assign s_zero  = (keypad_s == '0);
  assign s_same  = (keypad_s == sample);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      sample    <= '0;
      db_cnt    <= '0;
      rpt_cnt   <= '0;
      rpt_again <= 1'b0;
      keycode   <= '0;
      keystrobe <= 1'b0;
      keyheld   <= 1'b0;
    end else begin
      keystrobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!s_zero) begin
            state  <= S_DEBOUNCE;
            sample <= keypad_s;
            db_cnt <= DB_ONE;
          end
        end
        S_DEBOUNCE: begin
          if (s_zero) begin
            state <= S_IDLE;
          end else if (!s_same) begin
            sample <= keypad_s;
            db_cnt <= DB_ONE;
          end else if (db_cnt == DB_LIM) begin
            state     <= S_PRESSED;
            keycode   <= sample_code;
            keystrobe <= 1'b1;
            keyheld   <= 1'b1;
            rpt_cnt   <= '0;
            rpt_again <= 1'b0;
          end else begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end
        S_PRESSED: begin
          if (s_zero) begin
            state  <= S_RELEASE;
            db_cnt <= DB_ONE;
          end else if (!s_same) begin
            state   <= S_DEBOUNCE;
            sample  <= keypad_s;
            db_cnt  <= DB_ONE;
            keyheld <= 1'b0;
          end else if (REPEAT_EN != 0 && !sample_multi) begin
            if (rpt_nxt == rpt_lim) begin
              keystrobe <= 1'b1;
              rpt_cnt   <= '0;
              rpt_again <= 1'b1;
            end else begin
              rpt_cnt <= rpt_nxt;
            end
          end
        end
        S_RELEASE: begin
          if (s_zero) begin
            if (db_cnt == DB_LIM) begin
              state   <= S_IDLE;
              keyheld <= 1'b0;
            end else begin
              db_cnt <= db_cnt + DB_ONE;
            end
          end else if (s_same) begin
            // Release bounce: resume the held key silently, repeat timing restarts.
            state     <= S_PRESSED;
            rpt_cnt   <= '0;
            rpt_again <= 1'b0;
          end else begin
            state   <= S_DEBOUNCE;
            sample  <= keypad_s;
            db_cnt  <= DB_ONE;
            keyheld <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debounced_key_encoder.sv
// Bench for debounced_key_encoder: a default instance and an auto-repeat instance share
// one keypad; a run-length reference model feeds expected strobes and per-cycle outputs.
module tb_debounced_key_encoder;

  localparam int NK  = 13;
  localparam int DB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 4;

  logic          tb_clk = 1'b0;
  logic          nrst = 1'b0;
  logic [NK-1:0] keypad = '0;
  logic [3:0]    kc0, kc1;
  logic          ks0, ks1, kh0, kh1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 tb_clk = ~tb_clk;

  debounced_key_encoder dut0 (
    .clk(tb_clk), .nrst(nrst), .keypad(keypad),
    .keycode(kc0), .keystrobe(ks0), .keyheld(kh0)
  );

  debounced_key_encoder #(.REPEAT_EN(1), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)) dut1 (
    .clk(tb_clk), .nrst(nrst), .keypad(keypad),
    .keycode(kc1), .keystrobe(ks1), .keyheld(kh1)
  );

  typedef struct { int cyc; logic [3:0] code; } sev_t;
  typedef struct { bit held; logic [3:0] code; } cyc_t;

  sev_t sq0[$];
  sev_t sq1[$];
  cyc_t hq[$];

  // Reference model state: synchroniser delay line, run length of the synchronised
  // value, the currently held key and the edge at which it (re)entered the held state.
  int            cyc = 0;
  logic [NK-1:0] s1 = '0, s2 = '0, last_v = '0, held_val = '0;
  int            run = 0;
  bit            held_v = 0;
  int            t0 = 0;
  logic [3:0]    exp_code = '0;

  function automatic logic [3:0] ref_code(input logic [NK-1:0] v);
    if ($countones(v) > 1) return 4'hF;
    for (int i = 0; i < NK; i++) if (v[i]) return 4'(i);
    return 4'h0;
  endfunction

  always @(posedge tb_clk) begin
    logic [NK-1:0] v;
    bit acc, rep;
    int el;
    cyc++;
    acc = 0;
    rep = 0;
    if (!nrst) begin
      s1 = '0; s2 = '0; last_v = '0; run = 0; held_v = 0; exp_code = '0;
    end else begin
      v = s2; s2 = s1; s1 = keypad;
      if (v == last_v) run++; else run = 1;
      last_v = v;
      if (v == '0) begin
        if (held_v && run == DB + 1) held_v = 0;
      end else if (held_v && v == held_val) begin
        if (run == 1) t0 = cyc;
        else if ($countones(v) == 1) begin
          el = cyc - t0;
          if (el >= RDLY && (el - RDLY) % RPER == 0) rep = 1;
        end
      end else begin
        held_v = 0;
        if (run == DB + 1) begin
          held_v = 1; held_val = v; t0 = cyc; acc = 1;
          exp_code = ref_code(v);
        end
      end
    end
    if (acc) begin
      sq0.push_back('{cyc, exp_code});
      sq1.push_back('{cyc, exp_code});
    end
    if (rep) sq1.push_back('{cyc, exp_code});
    hq.push_back('{held_v, exp_code});
  end

  task automatic chk_strobe(input int k, input logic s, input logic [3:0] c);
    sev_t e;
    bit have;
    have = (k == 0) ? (sq0.size() > 0) : (sq1.size() > 0);
    if (have) e = (k == 0) ? sq0[0] : sq1[0];
    if (have && e.cyc <= cyc) begin
      if (k == 0) void'(sq0.pop_front()); else void'(sq1.pop_front());
      n_cmp++;
      if (s !== 1'b1 || c !== e.code || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL strobe dut%0d cyc=%0d: got strobe=%b code=%h, want strobe=1 code=%h at cyc %0d",
                 k, cyc, s, c, e.code, e.cyc);
      end
    end else if (s !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_strobe dut%0d cyc=%0d: got strobe=%b code=%h, want no strobe", k, cyc, s, c);
    end
  endtask

  always @(posedge tb_clk) begin
    cyc_t h;
    #1;
    if (hq.size() > 0) begin
      h = hq.pop_front();
      n_cmp++;
      if (kh0 !== h.held || kh1 !== h.held || kc0 !== h.code || kc1 !== h.code) begin
        n_fail++;
        $display("FAIL held_code cyc=%0d: got held=%b/%b code=%h/%h, want held=%b code=%h",
                 cyc, kh0, kh1, kc0, kc1, h.held, h.code);
      end
    end
    chk_strobe(0, ks0, kc0);
    chk_strobe(1, ks1, kc1);
  end

  task automatic drive(input logic [NK-1:0] val, input int n);
    keypad = val;
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic chk_reset_now(input string name);
    #1;
    n_cmp++;
    if (kc0 !== 4'h0 || ks0 !== 1'b0 || kh0 !== 1'b0 || kc1 !== 4'h0 || ks1 !== 1'b0 || kh1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got code=%h/%h strobe=%b/%b held=%b/%b, want all zero",
               name, kc0, kc1, ks0, ks1, kh0, kh1);
    end
  endtask

  initial begin
    logic [NK-1:0] prev, pat;
    int r, len;
    @(negedge tb_clk);
    // Reset held for two cycles with key 1 already down, then full-latency press.
    keypad = 13'h0002;
    repeat (2) @(negedge tb_clk);
    chk_reset_now("reset_hold");
    nrst = 1'b1;
    drive(13'h0002, 20);
    drive('0, 15);

    for (int i = 0; i < NK; i++) begin
      drive(13'(1) << i, 50);
      drive('0, 15);
    end

    drive(13'h0003, 60);
    drive('0, 15);

    // Press bounce on key 5, then a short release bounce.
    for (int i = 0; i < 5; i++) begin
      drive(13'h0020, 2);
      drive('0, 2);
    end
    drive(13'h0020, 30);
    drive('0, 3);
    drive(13'h0020, 20);
    drive('0, 15);

    drive(13'h0200, 40);
    drive('0, 15);

    // Reset asserted mid-debounce of key 3; key stays down through and after reset.
    drive(13'h0008, 5);
    nrst = 1'b0;
    chk_reset_now("reset_mid_debounce");
    @(negedge tb_clk);
    @(negedge tb_clk);
    nrst = 1'b1;
    drive(13'h0008, 20);
    drive('0, 15);

    prev = 13'h0001;
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 39);
      len = $urandom_range(1, 12);
      if (r == 0) begin
        nrst = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge tb_clk);
        nrst = 1'b1;
        continue;
      end
      case (r % 10)
        0, 1, 2: pat = '0;
        3, 4, 5, 6: pat = 13'(1) << $urandom_range(0, NK - 1);
        7: pat = (13'(1) << $urandom_range(0, NK - 1)) | (13'(1) << $urandom_range(0, NK - 1));
        8: pat = prev;
        default: begin
          pat = 13'(1) << $urandom_range(0, NK - 1);
          len = $urandom_range(1, 3);
        end
      endcase
      if (pat != '0) prev = pat;
      drive(pat, len);
    end
    drive('0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
